// File: rtl/cube_if.sv
// cube_if -- operand/result bundle for the cube block.
//   a_bi   : 8-bit unsigned operand x (sampled by cube while its rst_i is high)
//   busy_o : high while reset/start is asserted or a computation is in flight
//   y_bo   : 24-bit registered result x*x*x
// Modports: master drives the operand, slave (the cube block) drives the results.
interface cube_if;
  logic [7:0]  a_bi;
  logic        busy_o;
  logic [23:0] y_bo;

  modport master (output a_bi, input  busy_o, y_bo);
  modport slave  (input  a_bi, output busy_o, y_bo);
endinterface

// File: rtl/cube.sv
// cube -- computes y = x^3 with a shift-add datapath: a square phase (SQ)
// accumulates x*x one operand digit per cycle, then a cube phase (CB)
// accumulates sq*x the same way. No multiplier instance is used.
//
// Ports:
//   clk_i  : clock, all state updates on its rising edge
//   rst_i  : synchronous active-high reset that doubles as the start strobe;
//            every edge with rst_i=1 reloads x from bus.a_bi and clears y
//   bus    : cube_if.slave -- a_bi (operand), busy_o (comb), y_bo (result)
//
// Build option: define CUBE_RADIX4_EN to consume two operand bits per step
// (4+4 cycles instead of 8+8). Results are identical in both builds.
module cube (
  input  logic   clk_i,
  input  logic   rst_i,
  cube_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SQ, CB} state_t;

`ifdef CUBE_RADIX4_EN
  localparam logic [2:0] STEP = 3'd2;
  localparam logic [2:0] LAST = 3'd6;
`else
  localparam logic [2:0] STEP = 3'd1;
  localparam logic [2:0] LAST = 3'd7;
`endif

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [15:0] sq_q, sq_d;
  logic [23:0] acc_q, acc_d;
  logic [2:0]  ctr_q, ctr_d;
  logic [23:0] y_q, y_d;

  // Current multiplier digit taken from x at the counter position.
  logic [1:0]  dig;
  logic [23:0] mop, part, acc_sum;

`ifdef CUBE_RADIX4_EN
  assign dig = x_q[ctr_q +: 2];
`else
  assign dig = {1'b0, x_q[ctr_q]};
`endif

  // SQ multiplies x by x, CB multiplies the stored square by x.
  assign mop     = (state_q == SQ) ? {16'd0, x_q} : {8'd0, sq_q};
  assign part    = (dig[0] ? mop : 24'd0) + (dig[1] ? (mop << 1) : 24'd0);
  assign acc_sum = acc_q + (part << ctr_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    y_d     = y_q;
    case (state_q)
      SQ: begin
        acc_d = acc_sum;
        ctr_d = ctr_q + STEP;
        if (ctr_q == LAST) begin
          sq_d    = acc_sum[15:0];
          acc_d   = '0;
          ctr_d   = '0;
          state_d = CB;
        end
      end
      CB: begin
        acc_d = acc_sum;
        ctr_d = ctr_q + STEP;
        if (ctr_q == LAST) begin
          // Only this step publishes to y, so partial sums never show.
          y_d     = acc_sum;
          ctr_d   = '0;
          state_d = IDLE;
        end
      end
      default: ; // IDLE holds everything until the next start
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SQ;
      x_q     <= bus.a_bi;
      sq_q    <= '0;
      acc_q   <= '0;
      ctr_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      y_q     <= y_d;
    end
  end

  assign bus.busy_o = rst_i | (state_q != IDLE);
  assign bus.y_bo   = y_q;

endmodule

// File: tb/tb_cube.sv
// tb_cube -- self-checking bench for cube: directed corner values, random
// operands against an arithmetic x*x*x model, abort/restart, held reset,
// result stability and a cube-root round trip.
module tb_cube;

`ifdef CUBE_RADIX4_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  cube_if bus();

  cube dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input int x);
    return 24'(x * x * x);
  endfunction

  function automatic int cbrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Pulse rst_i for one edge with operand x, then drive junk on a_bi.
  task automatic start_op(input logic [7:0] x);
    @(negedge clk);
    rst      = 1'b1;
    bus.a_bi = x;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.a_bi = 8'($urandom);
  endtask

  // Walk LAT edges requiring busy=1 and y=0 throughout, then the result.
  task automatic finish_op(input logic [23:0] exp, input string nm);
    logic bad = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b1 || bus.y_bo !== 24'd0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (bad) $display("FAIL %s_window: busy/y deviated during %0d busy cycles", nm, LAT);
    else passes++;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.y_bo !== exp)
      $display("FAIL %s_result: got busy=%b y=%h, want busy=0 y=%h", nm, bus.busy_o, bus.y_bo, exp);
    else passes++;
  endtask

  task automatic test_reset;
    // busy is combinational on rst_i even before state is known.
    @(negedge clk);
    rst      = 1'b1;
    bus.a_bi = 8'd9;
    #1;
    checks++;
    if (bus.busy_o !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy_o);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.y_bo !== 24'd0) $display("FAIL reset_y: got %h want 0", bus.y_bo);
    else passes++;
    // Hold reset, reloading a_bi; only the last value counts.
    bus.a_bi = 8'd10;
    @(posedge clk);
    #1;
    bus.a_bi = 8'd4;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.y_bo !== 24'd0)
      $display("FAIL reset_hold: got busy=%b y=%h want 1/0", bus.busy_o, bus.y_bo);
    else passes++;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.a_bi = 8'd77;
    finish_op(model(4), "held_reset");
  endtask

  task automatic test_directed;
    logic [7:0] xs [4] = '{8'd0, 8'd5, 8'd1, 8'd255};
    foreach (xs[i]) begin
      start_op(xs[i]);
      finish_op(model(int'(xs[i])), $sformatf("directed_%0d", xs[i]));
    end
  endtask

  task automatic test_hold;
    // Result from the previous op (255) must stay put while idle.
    logic bad = 1'b0;
    bus.a_bi = 8'd17;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.y_bo !== 24'hFD02FF || bus.busy_o !== 1'b0) bad = 1'b1;
      bus.a_bi = 8'($urandom);
    end
    checks++;
    if (bad) $display("FAIL idle_hold: y=%h busy=%b want FD02FF/0", bus.y_bo, bus.busy_o);
    else passes++;
  endtask

  task automatic test_abort;
    logic bad = 1'b0;
    start_op(8'd200);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.y_bo !== 24'd0) bad = 1'b1;
    end
    // Edge 5 samples the restart.
    rst      = 1'b1;
    bus.a_bi = 8'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bad) $display("FAIL abort_pre: y=%h during aborted op, want 0", bus.y_bo);
    else passes++;
    finish_op(24'd27, "abort_restart");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] x = 8'($urandom);
      start_op(x);
      finish_op(model(int'(x)), $sformatf("random_%0d", x));
    end
  endtask

  task automatic test_roundtrip;
    for (int x = 0; x <= 6; x++) begin
      start_op(8'(x));
      finish_op(model(x), $sformatf("rt_%0d", x));
      checks++;
      if (cbrt(int'(bus.y_bo)) !== x)
        $display("FAIL roundtrip_%0d: cbrt(y)=%0d want %0d", x, cbrt(int'(bus.y_bo)), x);
      else passes++;
    end
  endtask

  initial begin
    bus.a_bi = 8'd0;
    test_reset;
    test_directed;
    test_hold;
    test_abort;
    test_random;
    test_roundtrip;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
